hex_line_writer: RTL and testbench

- Streaming writer for the pipeline's hex trace format: one word per line, DATA_W/4 hex digits MSB-first, terminated by LF (0x0A).
- Each line is accepted by a "%h\n" line reader, so pipeline outputs can be dumped to a file and read back.
- Sits at the pipeline output: 32-bit word valid/ready in, ASCII byte valid/ready out to the file/UART sink.
- A small input FIFO decouples the word producer from the character sink.

---
 rtl/hex_line_pkg.sv | 26 ++
 rtl/hex_line_writer_fifo.sv | 54 +++++
 rtl/hex_line_writer.sv | 129 ++++++++++++
 tb/tb_hex_line_writer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_line_pkg.sv
// Shared constants, FSM state type and digit-to-ASCII helper for the hex trace writer.
// Imported by the writer top and its input FIFO.
package hex_line_pkg;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_LA = 8'h61;
    localparam logic [7:0] CH_UA = 8'h41;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        EOL   = 2'd2
    } state_t;

    // Map one nibble to its ASCII hex digit; 'upper' selects the A-F alphabet.
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib, input logic upper);
        logic [7:0] base;
        if (nib < 4'd10) begin
            return CH_0 + {4'b0000, nib};
        end
        base = upper ? CH_UA : CH_LA;
        return base + {4'b0000, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/hex_line_writer_fifo.sv
// Small synchronous word FIFO decoupling the word producer from the character sink.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module word_fifo
    import hex_line_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they were written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/hex_line_writer.sv
// Streams each input word as a fixed-width line of hex digits, MSB first, terminated by LF.
// Words are buffered in word_fifo; the FSM drives a registered ASCII valid/ready output.
module hex_line_writer
    import hex_line_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int UPPERCASE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [7:0]        out_char,
    input  logic              out_ready,
    output logic              out_eol,
    output logic              busy,
    output logic [15:0]       lines_done
);

    localparam int   NDIG    = DATA_W / 4;
    localparam int   IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic C_UPPER = (UPPERCASE != 0);

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [IW-1:0]     r_idx;
    logic              r_out_valid;
    logic [7:0]        r_out_char;
    logic              r_out_eol;
    logic [15:0]       r_lines;

    logic [DATA_W-1:0] w_fifo_data;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_xfer;
    logic [DATA_W-1:0] w_shift_next;

    word_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_xfer       = r_out_valid && out_ready;
    assign w_shift_next = r_shift << 4;
    // A new word is loaded from idle, or straight after an LF so lines run back to back.
    assign w_pop        = !w_empty && ((r_state == IDLE) || ((r_state == EOL) && w_xfer));

    assign in_ready   = !w_full;
    assign out_valid  = r_out_valid;
    assign out_char   = r_out_char;
    assign out_eol    = r_out_eol;
    assign lines_done = r_lines;
    assign busy       = !w_empty || (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_char  <= 8'h00;
            r_out_eol   <= 1'b0;
            r_lines     <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state     <= DIGIT;
                        r_shift     <= w_fifo_data;
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_char  <= nib2ascii(w_fifo_data[DATA_W-1 -: 4], C_UPPER);
                        r_out_eol   <= 1'b0;
                    end
                end
                DIGIT: begin
                    if (w_xfer) begin
                        if (r_idx == IW'(NDIG - 1)) begin
                            r_state    <= EOL;
                            r_out_char <= CH_LF;
                            r_out_eol  <= 1'b1;
                        end else begin
                            r_shift    <= w_shift_next;
                            r_idx      <= r_idx + 1'b1;
                            r_out_char <= nib2ascii(w_shift_next[DATA_W-1 -: 4], C_UPPER);
                        end
                    end
                end
                EOL: begin
                    if (w_xfer) begin
                        r_lines <= r_lines + 16'd1;
                        if (w_pop) begin
                            r_state     <= DIGIT;
                            r_shift     <= w_fifo_data;
                            r_idx       <= '0;
                            r_out_char  <= nib2ascii(w_fifo_data[DATA_W-1 -: 4], C_UPPER);
                            r_out_eol   <= 1'b0;
                        end else begin
                            r_state     <= IDLE;
                            r_out_valid <= 1'b0;
                            r_out_char  <= 8'h00;
                            r_out_eol   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_out_char  <= 8'h00;
                    r_out_eol   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_line_writer.sv
// Directed self-checking bench for hex_line_writer: lowercase instance for most steps,
// a second UPPERCASE=1 instance for the A-F alphabet.
module tb_hex_line_writer;

    localparam int DATA_W = 32;
    localparam int NDIG   = DATA_W / 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              inValid;
    logic [DATA_W-1:0] inData;
    logic              inReady;
    logic              outValid;
    logic [7:0]        outChar;
    logic              outReady;
    logic              outEol;
    logic              busy;
    logic [15:0]       linesDone;

    logic              uInValid;
    logic [DATA_W-1:0] uInData;
    logic              uInReady;
    logic              uOutValid;
    logic [7:0]        uOutChar;
    logic              uOutReady;
    logic              uOutEol;
    logic              uBusy;
    logic [15:0]       uLinesDone;

    int compareCount = 0;
    int errCount     = 0;

    logic [7:0]        expQ[$];
    logic [DATA_W-1:0] sendQ[$];
    string             hexDigits = "0123456789abcdef";

    hex_line_writer #(.DATA_W(DATA_W), .FIFO_DEPTH(4), .UPPERCASE(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (inValid),
        .in_data    (inData),
        .in_ready   (inReady),
        .out_valid  (outValid),
        .out_char   (outChar),
        .out_ready  (outReady),
        .out_eol    (outEol),
        .busy       (busy),
        .lines_done (linesDone)
    );

    hex_line_writer #(.DATA_W(DATA_W), .FIFO_DEPTH(4), .UPPERCASE(1)) dutUpper (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (uInValid),
        .in_data    (uInData),
        .in_ready   (uInReady),
        .out_valid  (uOutValid),
        .out_char   (uOutChar),
        .out_ready  (uOutReady),
        .out_eol    (uOutEol),
        .busy       (uBusy),
        .lines_done (uLinesDone)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic queueLine(input logic [DATA_W-1:0] w);
        for (int i = NDIG - 1; i >= 0; i--) begin
            expQ.push_back(8'(hexDigits.getc(int'(w[i*4 +: 4]))));
        end
        expQ.push_back(8'h0A);
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] w);
        inValid = 1'b1;
        inData  = w;
        @(negedge clk);
        inValid = 1'b0;
    endtask

    // One character per cycle: valid, char and eol must be present right now.
    task automatic expectChar(input string tag, input logic [7:0] ch);
        checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
        checkOutput({tag, "_char"}, 32'(outChar), 32'(ch));
        checkOutput({tag, "_eol"}, 32'(outEol), 32'(ch == 8'h0A));
        @(negedge clk);
    endtask

    task automatic expectQueue(input string tag);
        while (expQ.size() > 0) begin
            expectChar(tag, expQ.pop_front());
        end
    endtask

    // Feeds sendQ and drains expQ under a repeating out_ready pattern, checking hold stability.
    task automatic runTraffic(input string tag, input logic [3:0] mask, input int maxCycles);
        int         cyc = 0;
        bit         prevStall = 1'b0;
        logic [7:0] prevChar = 8'h00;
        bit         accepted;
        bit         transferred;
        while (expQ.size() > 0 && cyc < maxCycles) begin
            outReady = mask[cyc[1:0]];
            if (prevStall) begin
                checkOutput({tag, "_hold_valid"}, 32'(outValid), 32'd1);
                checkOutput({tag, "_hold_char"}, 32'(outChar), 32'(prevChar));
            end
            if (outValid) begin
                checkOutput({tag, "_char"}, 32'(outChar), 32'(expQ[0]));
            end
            prevStall = outValid && !outReady;
            prevChar  = outChar;
            inValid   = (sendQ.size() > 0);
            if (inValid) inData = sendQ[0];
            accepted    = inValid && inReady;
            transferred = outValid && outReady;
            @(negedge clk);
            if (accepted) void'(sendQ.pop_front());
            if (transferred) void'(expQ.pop_front());
            cyc++;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        checkOutput({tag, "_chars_left"}, 32'(expQ.size()), 32'd0);
        checkOutput({tag, "_words_left"}, 32'(sendQ.size()), 32'd0);
        expQ.delete();
        sendQ.delete();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]        upExp[$];
        logic [DATA_W-1:0] dataNext;

        rst_n     = 1'b0;
        inValid   = 1'b0;
        inData    = '0;
        outReady  = 1'b1;
        uInValid  = 1'b0;
        uInData   = '0;
        uOutReady = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_out_char", 32'(outChar), 32'h00);
        checkOutput("rst_out_eol", 32'(outEol), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_lines", 32'(linesDone), 32'd0);
        checkOutput("rst_in_ready", 32'(inReady), 32'd1);

        $display("[TB] single word 0x0000084F");
        applyStimulus(32'h0000084F);
        checkOutput("single_latency_valid", 32'(outValid), 32'd0);
        checkOutput("single_busy_early", 32'(busy), 32'd1);
        @(negedge clk);
        expQ = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h38, 8'h34, 8'h66, 8'h0A};
        expectQueue("single");
        checkOutput("single_valid_after", 32'(outValid), 32'd0);
        checkOutput("single_busy_after", 32'(busy), 32'd0);
        checkOutput("single_lines", 32'(linesDone), 32'd1);

        $display("[TB] back-to-back words");
        inValid = 1'b1;
        inData  = 32'hDEADBEEF;
        @(negedge clk);
        inData  = 32'h00000001;
        @(negedge clk);
        inValid = 1'b0;
        expQ = '{8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0A,
                 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0A};
        expectQueue("b2b");
        checkOutput("b2b_valid_after", 32'(outValid), 32'd0);
        checkOutput("b2b_lines", 32'(linesDone), 32'd3);

        $display("[TB] backpressure 1,0,0,1");
        sendQ = '{32'hDEADBEEF, 32'h00000001};
        queueLine(32'hDEADBEEF);
        queueLine(32'h00000001);
        runTraffic("bp", 4'b1001, 200);
        @(negedge clk);
        checkOutput("bp_lines", 32'(linesDone), 32'd5);

        $display("[TB] fill with out_ready low");
        outReady = 1'b0;
        inValid  = 1'b1;
        dataNext = 32'd1;
        for (int i = 0; i < 8; i++) begin
            inData = dataNext;
            checkOutput($sformatf("full_in_ready_%0d", i), 32'(inReady), 32'(i < 5));
            if (inReady) dataNext = dataNext + 32'd1;
            @(negedge clk);
        end
        checkOutput("full_accepted", dataNext - 32'd1, 32'd5);
        checkOutput("full_busy", 32'(busy), 32'd1);
        checkOutput("full_lines_stalled", 32'(linesDone), 32'd5);
        for (int w = 1; w <= 8; w++) queueLine(DATA_W'(w));
        sendQ = '{32'd6, 32'd7, 32'd8};
        runTraffic("full", 4'b1111, 300);
        @(negedge clk);
        checkOutput("full_lines", 32'(linesDone), 32'd13);
        checkOutput("full_busy_after", 32'(busy), 32'd0);

        $display("[TB] uppercase instance");
        uInValid = 1'b1;
        uInData  = 32'hABCDEF09;
        @(negedge clk);
        uInValid = 1'b0;
        @(negedge clk);
        upExp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h30, 8'h39, 8'h0A};
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("upper_valid_%0d", i), 32'(uOutValid), 32'd1);
            checkOutput($sformatf("upper_char_%0d", i), 32'(uOutChar), 32'(upExp[i]));
            @(negedge clk);
        end
        checkOutput("upper_lines", 32'(uLinesDone), 32'd1);

        $display("[TB] reset mid-line");
        applyStimulus(32'h12345678);
        @(negedge clk);
        expectChar("midline_d0", 8'h31);
        expectChar("midline_d1", 8'h32);
        expectChar("midline_d2", 8'h33);
        rst_n = 1'b0;
        #1;
        checkOutput("midline_rst_valid", 32'(outValid), 32'd0);
        checkOutput("midline_rst_lines", 32'(linesDone), 32'd0);
        checkOutput("midline_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midline_in_ready", 32'(inReady), 32'd1);
        checkOutput("midline_idle_valid", 32'(outValid), 32'd0);
        applyStimulus(32'h0000000A);
        @(negedge clk);
        expQ = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h61, 8'h0A};
        expectQueue("after_rst");
        checkOutput("after_rst_lines", 32'(linesDone), 32'd1);
        checkOutput("after_rst_valid", 32'(outValid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
        $finish;
    end

endmodule
